ttt_neuron_bank: RTL and testbench
==================================

Name: ttt_neuron_bank

Overview:
- Parametrised successor to the single tick-tock-token core: a bank of NUM_NEURONS token-counting neurons sharing one datapath.
- Tick phase: accepts signed input tokens addressed to any neuron. Tock phase: sweeps all neurons in index order and emits output-spike tokens on a ready/valid stream.
- Sits between the pin-level I/O shim (token and config decoding) and the output serialiser inside the top-level wrapper.

Parameters:
- NUM_NEURONS, 4, number of neurons (2..16).
- COUNT_WIDTH, 8, width of each unsigned token counter and threshold.
- THRESH_INIT, 4, threshold loaded into every neuron at reset.
- ADDR_WIDTH, $clog2(NUM_NEURONS), neuron index width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- tok_valid  in  1  input token present
- tok_ready  out  1  token accepted when valid&&ready
- tok_addr  in  ADDR_WIDTH  target neuron
- tok_sign  in  1  0 = excitatory (+1), 1 = inhibitory (-1)
- cfg_valid  in  1  threshold write request
- cfg_ready  out  1  write accepted when valid&&ready
- cfg_addr  in  ADDR_WIDTH  neuron to configure
- cfg_threshold  in  COUNT_WIDTH  new threshold
- step  in  1  start tock sweep (sampled in ACCEPT only)
- spk_valid  out  1  output spike present
- spk_ready  in  1  downstream accepts spike
- spk_addr  out  ADDR_WIDTH  index of spiking neuron
- sweep_done  out  1  one-cycle pulse when a sweep completes

Behaviour:
- Reset: all counters 0; all thresholds THRESH_INIT; state ACCEPT; spk_valid=0, spk_addr=0, sweep_done=0. rst mid-sweep aborts the sweep and drops any pending spike.
- FSM states:
  - ACCEPT: tok_ready=1, cfg_ready=1. step=1 → SWEEP with idx=0 next cycle.
  - SWEEP: tok_ready=0, cfg_ready=0. Evaluate neuron idx.
    - Fires if threshold!=0 and count>=threshold: count<=count-threshold; spk_valid<=1; spk_addr<=idx; → EMIT.
    - Otherwise: idx==NUM_NEURONS-1 → DONE, else idx+1.
  - EMIT: hold spk_valid and spk_addr stable until spk_ready=1. On handshake: spk_valid<=0, then idx+1 → SWEEP, or DONE if idx is last.
  - DONE: sweep_done=1 for exactly one cycle → ACCEPT.
- Token arithmetic: unsigned, saturating. +1 at 2^COUNT_WIDTH-1 stays at max; -1 at 0 stays at 0. One token per cycle.
- Same cycle in ACCEPT:
  - token and step: token applied, sweep starts next cycle and sees the updated count.
  - cfg and token to the same neuron: both take effect (threshold written, count updated).
  - cfg and step: threshold written and used by the sweep.
- threshold=0 disables a neuron: it never fires, and its count still accumulates.
- Minimum sweep length with no spikes: NUM_NEURONS+1 cycles from step to sweep_done. Each spike adds at least 1 cycle.

Optional Feature:
- Macro: TTT_LEAK_EN.
- With it: in SWEEP, a non-firing neuron with count>0 loses 1 (leak). Firing neurons do not leak.
- Without it: counts persist unchanged across sweeps except on firing.

Decomposition:
- Package ttt_pkg: state enum (ACCEPT, SWEEP, EMIT, DONE); token sign constants TOK_EXC=1'b0, TOK_INH=1'b1; saturating add/sub function parameterised by width.
- One sub-module: ttt_neuron_cell (one counter + threshold register, with inc/dec/fire/leak controls), instantiated NUM_NEURONS times. Bank FSM and sweep index stay in ttt_neuron_bank.

Test Plan:
- Reset then idle step → no spk_valid; sweep_done pulses exactly 5 cycles after step (NUM_NEURONS=4); tok_ready=1 again afterwards.
- 5 excitatory tokens to neuron 2, 1 inhibitory to neuron 2, step → one spike with spk_addr=2; neuron 2 count afterwards 0 (6-2... i.e. 5-1=4, 4-4=0).
- cfg neuron 1 threshold=3; 7 tokens to neuron 1; step with spk_ready held 0 for 4 cycles → spk_valid/spk_addr=1 stable throughout. Count left at 4 (no leak) or 4 (fired neurons never leak). Second step → spike again, count 1.
- 260 excitatory tokens to neuron 0 (COUNT_WIDTH=8) → count 255. 300 inhibitory tokens to neuron 3 → count stays 0, no wrap.
- With TTT_LEAK_EN: 2 tokens to neuron 0, threshold 4; two steps → count 0 after the second sweep, no spike. Without the macro: count stays 2.
- Spikes on neurons 0 and 3 in one sweep → spikes emitted in order 0 then 3. Assert rst during the EMIT of neuron 0 → spk_valid=0 next cycle, counts all 0.

Source files
------------

// File: rtl/ttt_neuron_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ttt_pkg
// Description : Shared definitions for the tick-tock-token neuron bank:
//               FSM state encodings, token sign constants and a saturating
//               unsigned +/-1 helper usable at any counter width up to 32.
// Revision    : 1.0 - initial release
// ============================================================================
package ttt_pkg;

    // Bank FSM state encodings
    typedef logic [1:0] ttt_state_t;
    localparam ttt_state_t ST_ACCEPT = 2'd0;
    localparam ttt_state_t ST_SWEEP  = 2'd1;
    localparam ttt_state_t ST_EMIT   = 2'd2;
    localparam ttt_state_t ST_DONE   = 2'd3;

    // Token polarity as carried on tok_sign
    localparam logic TOK_EXC = 1'b0;
    localparam logic TOK_INH = 1'b1;

    // Saturating step of an unsigned value held in the low 'width' bits:
    // +1 clamps at 2^width-1, -1 clamps at 0.
    function automatic logic [31:0] sat_step(input logic [31:0] value,
                                             input logic        down,
                                             input int          width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        if (down) begin
            sat_step = (value == 32'd0) ? 32'd0 : value - 32'd1;
        end else begin
            sat_step = (value >= max_val) ? max_val : value + 32'd1;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/ttt_neuron_bank_cell.sv
`default_nettype none
// ============================================================================
// Module      : ttt_neuron_cell
// Description : One token-counting neuron: saturating counter plus threshold
//               register. Fire subtracts the threshold, leak removes one
//               token, inc/dec apply a saturating token.
// Revision    : 1.0 - initial release
// ============================================================================
module ttt_neuron_cell
    import ttt_pkg::*;
#(
    parameter int COUNT_WIDTH = 8,
    parameter int THRESH_INIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_inc,
    input  logic                   i_dec,
    input  logic                   i_fire,
    input  logic                   i_leak,
    input  logic                   i_cfg_we,
    input  logic [COUNT_WIDTH-1:0] i_cfg_threshold,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic [COUNT_WIDTH-1:0] o_threshold
);

    localparam logic [COUNT_WIDTH-1:0] c_ONE  = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] c_INIT = COUNT_WIDTH'(THRESH_INIT);

    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] r_threshold;
    logic [COUNT_WIDTH-1:0] w_count_next;

    // Next counter value; fire/leak only occur during a sweep, tokens only
    // outside one, so the priority order never hides a real event.
    always_comb begin
        w_count_next = r_count;
        if (i_fire) begin
            w_count_next = r_count - r_threshold;
        end else if (i_leak && (r_count != '0)) begin
            w_count_next = r_count - c_ONE;
        end else if (i_inc) begin
            w_count_next = COUNT_WIDTH'(sat_step(32'(r_count), 1'b0, COUNT_WIDTH));
        end else if (i_dec) begin
            w_count_next = COUNT_WIDTH'(sat_step(32'(r_count), 1'b1, COUNT_WIDTH));
        end
    end

    // Counter and threshold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_threshold <= c_INIT;
        end else begin
            r_count <= w_count_next;
            if (i_cfg_we) begin
                r_threshold <= i_cfg_threshold;
            end
        end
    end

    assign o_count     = r_count;
    assign o_threshold = r_threshold;

endmodule
`default_nettype wire

// File: rtl/ttt_neuron_bank.sv
`default_nettype none
// ============================================================================
// Module      : ttt_neuron_bank
// Description : Bank of NUM_NEURONS tick-tock-token neurons. Tick phase
//               (ACCEPT) takes tokens and threshold writes; tock phase sweeps
//               every neuron in index order and streams spike indices out
//               on a ready/valid port, then pulses sweep_done.
//               Optional macro TTT_LEAK_EN: non-firing neurons lose one
//               token per sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module ttt_neuron_bank
    import ttt_pkg::*;
#(
    parameter int NUM_NEURONS = 4,
    parameter int COUNT_WIDTH = 8,
    parameter int THRESH_INIT = 4,
    parameter int ADDR_WIDTH  = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tok_valid,
    output logic                   tok_ready,
    input  logic [ADDR_WIDTH-1:0]  tok_addr,
    input  logic                   tok_sign,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [ADDR_WIDTH-1:0]  cfg_addr,
    input  logic [COUNT_WIDTH-1:0] cfg_threshold,
    input  logic                   step,
    output logic                   spk_valid,
    input  logic                   spk_ready,
    output logic [ADDR_WIDTH-1:0]  spk_addr,
    output logic                   sweep_done
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST = ADDR_WIDTH'(NUM_NEURONS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_ONE  = ADDR_WIDTH'(1);

    ttt_state_t             r_state;
    logic [ADDR_WIDTH-1:0]  r_idx;
    logic                   r_spk_valid;
    logic [ADDR_WIDTH-1:0]  r_spk_addr;

    logic [COUNT_WIDTH-1:0] w_counts     [NUM_NEURONS];
    logic [COUNT_WIDTH-1:0] w_thresholds [NUM_NEURONS];
    logic [COUNT_WIDTH-1:0] w_cur_count;
    logic [COUNT_WIDTH-1:0] w_cur_thr;
    logic                   w_accept;
    logic                   w_in_sweep;
    logic                   w_fire_now;
    logic                   w_leak_now;

    assign w_accept    = (r_state == ST_ACCEPT);
    assign w_in_sweep  = (r_state == ST_SWEEP);
    assign w_cur_count = w_counts[r_idx];
    assign w_cur_thr   = w_thresholds[r_idx];

    // A zero threshold disables firing but not accumulation
    assign w_fire_now  = w_in_sweep && (w_cur_thr != '0) && (w_cur_count >= w_cur_thr);

`ifdef TTT_LEAK_EN
    assign w_leak_now  = w_in_sweep && !w_fire_now;
`else
    assign w_leak_now  = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_cell
            logic w_tok_hit;
            logic w_sel;
            assign w_tok_hit = w_accept && tok_valid && (tok_addr == ADDR_WIDTH'(gi));
            assign w_sel     = (r_idx == ADDR_WIDTH'(gi));

            ttt_neuron_cell #(
                .COUNT_WIDTH (COUNT_WIDTH),
                .THRESH_INIT (THRESH_INIT)
            ) u_cell (
                .clk             (clk),
                .rst             (rst),
                .i_inc           (w_tok_hit && (tok_sign == TOK_EXC)),
                .i_dec           (w_tok_hit && (tok_sign == TOK_INH)),
                .i_fire          (w_fire_now && w_sel),
                .i_leak          (w_leak_now && w_sel),
                .i_cfg_we        (w_accept && cfg_valid && (cfg_addr == ADDR_WIDTH'(gi))),
                .i_cfg_threshold (cfg_threshold),
                .o_count         (w_counts[gi]),
                .o_threshold     (w_thresholds[gi])
            );
        end
    endgenerate

    // Sweep FSM: index walk, spike register and handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCEPT;
            r_idx       <= '0;
            r_spk_valid <= 1'b0;
            r_spk_addr  <= '0;
        end else begin
            case (r_state)
                ST_ACCEPT: begin
                    if (step) begin
                        r_state <= ST_SWEEP;
                        r_idx   <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (w_fire_now) begin
                        r_spk_valid <= 1'b1;
                        r_spk_addr  <= r_idx;
                        r_state     <= ST_EMIT;
                    end else if (r_idx == c_LAST) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + c_ONE;
                    end
                end
                ST_EMIT: begin
                    if (spk_ready) begin
                        r_spk_valid <= 1'b0;
                        if (r_idx == c_LAST) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + c_ONE;
                            r_state <= ST_SWEEP;
                        end
                    end
                end
                default: begin
                    r_state <= ST_ACCEPT;
                end
            endcase
        end
    end

    assign tok_ready  = w_accept;
    assign cfg_ready  = w_accept;
    assign spk_valid  = r_spk_valid;
    assign spk_addr   = r_spk_addr;
    assign sweep_done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ttt_neuron_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_ttt_neuron_bank
// Description : Directed self-checking bench for ttt_neuron_bank
//               (NUM_NEURONS=4, COUNT_WIDTH=8, THRESH_INIT=4). Expectations
//               adapt to the TTT_LEAK_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ttt_neuron_bank;
    import ttt_pkg::*;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tok_valid = 1'b0;
    logic          tok_ready;
    logic [AW-1:0] tok_addr = '0;
    logic          tok_sign = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [AW-1:0] cfg_addr = '0;
    logic [CW-1:0] cfg_threshold = '0;
    logic          step = 1'b0;
    logic          spk_valid;
    logic          spk_ready = 1'b1;
    logic [AW-1:0] spk_addr;
    logic          sweep_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ttt_neuron_bank #(
        .NUM_NEURONS (N),
        .COUNT_WIDTH (CW),
        .THRESH_INIT (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tok_valid     (tok_valid),
        .tok_ready     (tok_ready),
        .tok_addr      (tok_addr),
        .tok_sign      (tok_sign),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_addr      (cfg_addr),
        .cfg_threshold (cfg_threshold),
        .step          (step),
        .spk_valid     (spk_valid),
        .spk_ready     (spk_ready),
        .spk_addr      (spk_addr),
        .sweep_done    (sweep_done)
    );

    function automatic int count_of(input int i);
        case (i)
            0:       count_of = int'(dut.g_cell[0].u_cell.o_count);
            1:       count_of = int'(dut.g_cell[1].u_cell.o_count);
            2:       count_of = int'(dut.g_cell[2].u_cell.o_count);
            default: count_of = int'(dut.g_cell[3].u_cell.o_count);
        endcase
    endfunction

    function automatic int thr_of(input int i);
        case (i)
            0:       thr_of = int'(dut.g_cell[0].u_cell.o_threshold);
            1:       thr_of = int'(dut.g_cell[1].u_cell.o_threshold);
            2:       thr_of = int'(dut.g_cell[2].u_cell.o_threshold);
            default: thr_of = int'(dut.g_cell[3].u_cell.o_threshold);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; tok_valid = 1'b0; cfg_valid = 1'b0; step = 1'b0; spk_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic send_tok(input int addr, input logic sign, input int n);
        tok_valid = 1'b1; tok_addr = AW'(addr); tok_sign = sign;
        repeat (n) tick();
        tok_valid = 1'b0;
    endtask

    task automatic write_cfg(input int addr, input int thr);
        cfg_valid = 1'b1; cfg_addr = AW'(addr); cfg_threshold = CW'(thr);
        tick();
        cfg_valid = 1'b0;
    endtask

    // Raise step (with whatever token/cfg the caller left driven), then
    // record spikes with spk_ready high until sweep_done or the budget runs out.
    task automatic run_sweep(output int cycles, output int nspk,
                             output int a0, output int a1, output bit timed_out);
        cycles = 0; nspk = 0; a0 = -1; a1 = -1; timed_out = 1'b0;
        spk_ready = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0; tok_valid = 1'b0; cfg_valid = 1'b0;
        cycles = 1;
        while (!sweep_done) begin
            if (spk_valid) begin
                if (nspk == 0) a0 = int'(spk_addr);
                else if (nspk == 1) a1 = int'(spk_addr);
                nspk++;
            end
            if (cycles >= 200) begin
                timed_out = 1'b1;
                break;
            end
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (tok_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tok_ready: got %b expected 1", tok_ready); end
        n_tests++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
        n_tests++; if (spk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_spk_valid: got %b expected 0", spk_valid); end
        n_tests++; if (spk_addr !== 2'd0) begin n_fail++; $display("FAIL reset_spk_addr: got %0d expected 0", spk_addr); end
        n_tests++; if (sweep_done !== 1'b0) begin n_fail++; $display("FAIL reset_sweep_done: got %b expected 0", sweep_done); end
        for (int i = 0; i < N; i++) begin
            n_tests++; if (count_of(i) != 0) begin n_fail++; $display("FAIL reset_count[%0d]: got %0d expected 0", i, count_of(i)); end
            n_tests++; if (thr_of(i) != 4) begin n_fail++; $display("FAIL reset_thr[%0d]: got %0d expected 4", i, thr_of(i)); end
        end
    endtask

    task automatic test_idle_sweep();
        int cyc, ns, a0, a1; bit to;
        do_reset();
        run_sweep(cyc, ns, a0, a1, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL idle_timeout: got timeout expected sweep_done"); end
        n_tests++; if (cyc != 5) begin n_fail++; $display("FAIL idle_latency: got %0d expected 5", cyc); end
        n_tests++; if (ns != 0) begin n_fail++; $display("FAIL idle_spikes: got %0d expected 0", ns); end
        tick();
        n_tests++; if (sweep_done !== 1'b0) begin n_fail++; $display("FAIL idle_done_pulse: got %b expected 0", sweep_done); end
        n_tests++; if (tok_ready !== 1'b1) begin n_fail++; $display("FAIL idle_tok_ready_after: got %b expected 1", tok_ready); end
    endtask

    task automatic test_excite_inhibit();
        int cyc, ns, a0, a1; bit to;
        do_reset();
        send_tok(2, TOK_EXC, 5);
        send_tok(2, TOK_INH, 1);
        n_tests++; if (count_of(2) != 4) begin n_fail++; $display("FAIL exinh_count_pre: got %0d expected 4", count_of(2)); end
        run_sweep(cyc, ns, a0, a1, to);
        n_tests++; if (to || ns != 1 || a0 != 2) begin n_fail++; $display("FAIL exinh_spike: got n=%0d addr=%0d to=%0d expected n=1 addr=2 to=0", ns, a0, to); end
        n_tests++; if (cyc != 6) begin n_fail++; $display("FAIL exinh_latency: got %0d expected 6", cyc); end
        n_tests++; if (count_of(2) != 0) begin n_fail++; $display("FAIL exinh_count_post: got %0d expected 0", count_of(2)); end
    endtask

    task automatic test_backpressure();
        int cyc, ns, a0, a1, k; bit to;
        do_reset();
        write_cfg(1, 3);
        send_tok(1, TOK_EXC, 7);
        spk_ready = 1'b0;
        step = 1'b1; tick(); step = 1'b0;
        k = 0;
        while (!spk_valid && k < 20) begin tick(); k++; end
        n_tests++; if (spk_valid !== 1'b1 || spk_addr !== 2'd1) begin n_fail++; $display("FAIL bp_first_spike: got v=%b addr=%0d expected v=1 addr=1", spk_valid, spk_addr); end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_tests++; if (spk_valid !== 1'b1 || spk_addr !== 2'd1 || tok_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b addr=%0d rdy=%b expected v=1 addr=1 rdy=0", c, spk_valid, spk_addr, tok_ready); end
        end
        spk_ready = 1'b1;
        k = 0;
        while (!sweep_done && k < 20) begin tick(); k++; end
        n_tests++; if (sweep_done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b expected 1", sweep_done); end
        n_tests++; if (count_of(1) != 4) begin n_fail++; $display("FAIL bp_count1: got %0d expected 4", count_of(1)); end
        tick();
        run_sweep(cyc, ns, a0, a1, to);
        n_tests++; if (to || ns != 1 || a0 != 1) begin n_fail++; $display("FAIL bp_second_spike: got n=%0d addr=%0d to=%0d expected n=1 addr=1 to=0", ns, a0, to); end
        n_tests++; if (count_of(1) != 1) begin n_fail++; $display("FAIL bp_count2: got %0d expected 1", count_of(1)); end
    endtask

    task automatic test_saturation();
        do_reset();
        send_tok(0, TOK_EXC, 260);
        n_tests++; if (count_of(0) != 255) begin n_fail++; $display("FAIL sat_max: got %0d expected 255", count_of(0)); end
        send_tok(3, TOK_INH, 300);
        n_tests++; if (count_of(3) != 0) begin n_fail++; $display("FAIL sat_min: got %0d expected 0", count_of(3)); end
        send_tok(0, TOK_INH, 1);
        n_tests++; if (count_of(0) != 254) begin n_fail++; $display("FAIL sat_dec_from_max: got %0d expected 254", count_of(0)); end
    endtask

    task automatic test_same_cycle();
        int cyc, ns, a0, a1; bit to;
        do_reset();
        // cfg threshold 0 and token to the same neuron in one cycle
        cfg_valid = 1'b1; cfg_addr = 2'd1; cfg_threshold = 8'd0;
        tok_valid = 1'b1; tok_addr = 2'd1; tok_sign = TOK_EXC;
        tick();
        cfg_valid = 1'b0;
        tok_valid = 1'b0;
        n_tests++; if (thr_of(1) != 0 || count_of(1) != 1) begin n_fail++; $display("FAIL same_cfg_tok: got thr=%0d cnt=%0d expected thr=0 cnt=1", thr_of(1), count_of(1)); end
        send_tok(1, TOK_EXC, 4);
        send_tok(2, TOK_EXC, 1);
        // step + token + cfg on neuron 2 together: sweep sees count 2, threshold 2
        cfg_valid = 1'b1; cfg_addr = 2'd2; cfg_threshold = 8'd2;
        tok_valid = 1'b1; tok_addr = 2'd2; tok_sign = TOK_EXC;
        run_sweep(cyc, ns, a0, a1, to);
        n_tests++; if (to || ns != 1 || a0 != 2) begin n_fail++; $display("FAIL same_step_spike: got n=%0d addr=%0d to=%0d expected n=1 addr=2 to=0", ns, a0, to); end
        n_tests++; if (count_of(2) != 0) begin n_fail++; $display("FAIL same_step_count: got %0d expected 0", count_of(2)); end
`ifdef TTT_LEAK_EN
        n_tests++; if (count_of(1) != 4) begin n_fail++; $display("FAIL thr0_count: got %0d expected 4", count_of(1)); end
`else
        n_tests++; if (count_of(1) != 5) begin n_fail++; $display("FAIL thr0_count: got %0d expected 5", count_of(1)); end
`endif
    endtask

    task automatic test_leak();
        int cyc, ns, a0, a1; bit to;
        int total;
        do_reset();
        send_tok(0, TOK_EXC, 2);
        run_sweep(cyc, ns, a0, a1, to);
        total = ns;
        tick();
        run_sweep(cyc, ns, a0, a1, to);
        total += ns;
        n_tests++; if (to || total != 0) begin n_fail++; $display("FAIL leak_spikes: got %0d to=%0d expected 0 to=0", total, to); end
`ifdef TTT_LEAK_EN
        n_tests++; if (count_of(0) != 0) begin n_fail++; $display("FAIL leak_count: got %0d expected 0", count_of(0)); end
`else
        n_tests++; if (count_of(0) != 2) begin n_fail++; $display("FAIL leak_count: got %0d expected 2", count_of(0)); end
`endif
    endtask

    task automatic test_order_and_reset();
        int cyc, ns, a0, a1, k; bit to;
        do_reset();
        send_tok(0, TOK_EXC, 4);
        send_tok(3, TOK_EXC, 4);
        run_sweep(cyc, ns, a0, a1, to);
        n_tests++; if (to || ns != 2 || a0 != 0 || a1 != 3) begin n_fail++; $display("FAIL order: got n=%0d a0=%0d a1=%0d to=%0d expected n=2 a0=0 a1=3 to=0", ns, a0, a1, to); end
        n_tests++; if (cyc != 7) begin n_fail++; $display("FAIL order_latency: got %0d expected 7", cyc); end
        tick();
        send_tok(0, TOK_EXC, 5);
        send_tok(3, TOK_EXC, 6);
        spk_ready = 1'b0;
        step = 1'b1; tick(); step = 1'b0;
        k = 0;
        while (!spk_valid && k < 20) begin tick(); k++; end
        n_tests++; if (spk_valid !== 1'b1 || spk_addr !== 2'd0) begin n_fail++; $display("FAIL rst_pre_emit: got v=%b addr=%0d expected v=1 addr=0", spk_valid, spk_addr); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        spk_ready = 1'b1;
        n_tests++; if (spk_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_emit_valid: got %b expected 0", spk_valid); end
        n_tests++; if (tok_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_emit_accept: got %b expected 1", tok_ready); end
        for (int i = 0; i < N; i++) begin
            n_tests++; if (count_of(i) != 0) begin n_fail++; $display("FAIL rst_mid_emit_count[%0d]: got %0d expected 0", i, count_of(i)); end
        end
    endtask

    initial begin
        test_reset();
        test_idle_sweep();
        test_excite_inhibit();
        test_backpressure();
        test_saturation();
        test_same_cycle();
        test_leak();
        test_order_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
